// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding
// word requests to instruction memory and buffers returned instructions.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] TargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        InstrValidF,
    output logic        branched_flag_F
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]       state, state_d;
    logic [31:0]      fpc, fpc_d;
    logic             stale, stale_d;
    logic [31:0]      stale_addr, stale_addr_d;
    logic [31:0]      wait_addr, wait_addr_d;
    logic             redir_pending, redir_pending_d;
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count, count_d;

    logic [31:0] buf_pc    [BUF_DEPTH];
    logic [31:0] buf_instr [BUF_DEPTH];
    logic        buf_redir [BUF_DEPTH];

    logic        redirect_c;
    logic [31:0] target_c;
    logic        head_valid_c;
    logic        pop_c;
    logic        push_c;
    logic        flush_c;
    logic [31:0] aligned_fpc_c;
    logic        unused_bits;

    assign unused_bits   = TargetE[0];
    assign redirect_c    = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    assign target_c      = (PCSrcE == 2'b01) ? {TargetE[31:2], 2'b00}
                                             : {TargetE[31:1], 1'b0};
    assign head_valid_c  = (count != '0);
    assign pop_c         = head_valid_c && !StallF;
    assign push_c        = (state == ST_WAIT) && imem_rvalid && !redirect_c;
    assign flush_c       = redirect_c;
    assign aligned_fpc_c = {fpc[31:2], 2'b00};

    // A request caught by a redirect before its grant keeps its old address.
    assign imem_req  = (state == ST_ISSUE);
    assign imem_addr = stale ? stale_addr : aligned_fpc_c;

    // Buffer occupancy after this edge's push/pop (or flush).
    always_comb begin
        count_d = count;
        if (flush_c) begin
            count_d = '0;
        end else begin
            count_d = count + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Next-state logic: normal handshake first, redirect overrides after.
    always_comb begin
        state_d         = state;
        fpc_d           = fpc;
        stale_d         = stale;
        stale_addr_d    = stale_addr;
        wait_addr_d     = wait_addr;
        redir_pending_d = redir_pending;

        case (state)
            ST_ISSUE: begin
                if (imem_gnt) begin
                    stale_d = 1'b0;
                    if (stale) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d     = ST_WAIT;
                        fpc_d       = fpc + 32'd4;
                        wait_addr_d = imem_addr;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    redir_pending_d = 1'b0;
                    state_d = (count_d < CNT_W'(BUF_DEPTH)) ? ST_ISSUE : ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_HOLD: begin
                if (pop_c) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase

        if (redirect_c) begin
            fpc_d           = target_c;
            redir_pending_d = 1'b1;
            case (state)
                ST_ISSUE: begin
                    if (imem_gnt) begin
                        state_d = ST_DRAIN;
                        stale_d = 1'b0;
                    end else begin
                        state_d = ST_ISSUE;
                        if (!stale) begin
                            stale_d      = 1'b1;
                            stale_addr_d = imem_addr;
                        end
                    end
                end
                // A response arriving with the redirect is consumed and dropped here.
                ST_WAIT:  state_d = imem_rvalid ? ST_ISSUE : ST_DRAIN;
                ST_DRAIN: state_d = imem_rvalid ? ST_ISSUE : ST_DRAIN;
                ST_HOLD:  state_d = ST_ISSUE;
                default:  state_d = ST_ISSUE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_ISSUE;
            fpc           <= RESET_PC;
            stale         <= 1'b0;
            stale_addr    <= 32'd0;
            wait_addr     <= 32'd0;
            redir_pending <= 1'b0;
            count         <= '0;
            head          <= '0;
            tail          <= '0;
        end else begin
            state         <= state_d;
            fpc           <= fpc_d;
            stale         <= stale_d;
            stale_addr    <= stale_addr_d;
            wait_addr     <= wait_addr_d;
            redir_pending <= redir_pending_d;
            count         <= count_d;
            if (flush_c) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push_c) tail <= tail + PTR_W'(1);
                if (pop_c)  head <= head + PTR_W'(1);
            end
        end
    end

    // Buffer payload storage; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_c) begin
            buf_pc[tail]    <= wait_addr;
            buf_instr[tail] <= imem_rdata;
            buf_redir[tail] <= redir_pending;
        end
    end

    assign InstrValidF     = head_valid_c;
    assign InstrF          = head_valid_c ? buf_instr[head] : NOP_INSTR;
    assign PCF             = head_valid_c ? buf_pc[head] : 32'd0;
    assign PCPlus4F        = PCF + 32'd4;
    assign branched_flag_F = head_valid_c && buf_redir[head];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory is either driven by hand or by a
// one-cycle responder returning 0xA000_0000 | addr.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic [1:0]  PCSrcE;
    logic [31:0] TargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        InstrValidF;
    logic        branched_flag_F;

    int n_cmp  = 0;
    int n_fail = 0;

    bit          auto_mem = 1'b0;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;
    logic        a_gnt = 1'b0, a_rvalid = 1'b0;
    logic [31:0] a_rdata = 32'd0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .StallF         (StallF),
        .PCSrcE         (PCSrcE),
        .TargetE        (TargetE),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .InstrF         (InstrF),
        .PCF            (PCF),
        .PCPlus4F       (PCPlus4F),
        .InstrValidF    (InstrValidF),
        .branched_flag_F(branched_flag_F)
    );

    assign imem_gnt    = auto_mem ? a_gnt    : m_gnt;
    assign imem_rvalid = auto_mem ? a_rvalid : m_rvalid;
    assign imem_rdata  = auto_mem ? a_rdata  : m_rdata;

    // Always-ready memory: grant any request, respond the following cycle.
    always @(negedge clk) begin
        if (auto_mem) begin
            a_rvalid  = pend;
            a_rdata   = 32'hA000_0000 | pend_addr;
            a_gnt     = imem_req;
            pend      = imem_req;
            pend_addr = imem_addr;
        end else begin
            a_gnt    = 1'b0;
            a_rvalid = 1'b0;
            pend     = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (InstrValidF === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        auto_mem = 1'b0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0;
        StallF = 1'b0; PCSrcE = 2'b00; TargetE = 32'd0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        auto_mem = 1'b0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0;
        StallF = 1'b0; PCSrcE = 2'b00; TargetE = 32'd0;
        reset = 1'b0;
        #13;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || InstrValidF !== 1'b0 ||
            InstrF !== 32'h0000_0013 || PCF !== 32'h0 || PCPlus4F !== 32'h4 ||
            branched_flag_F !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h flag=%b, required 1 0 0 00000013 0 4 0",
                     imem_req, imem_addr, InstrValidF, InstrF, PCF, PCPlus4F, branched_flag_F);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] exp_pc;
        do_reset();
        auto_mem = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_pc = 32'(k * 4);
            wait_valid(ok);
            n_cmp++;
            if (!ok || PCF !== exp_pc || InstrF !== (32'hA000_0000 | exp_pc) ||
                PCPlus4F !== exp_pc + 32'd4 || branched_flag_F !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_fetch%0d: valid=%b pc=%h instr=%h pc4=%h flag=%b, required pc=%h instr=%h flag=0",
                         k, ok, PCF, InstrF, PCPlus4F, branched_flag_F, exp_pc, 32'hA000_0000 | exp_pc);
            end
        end
    endtask

    // Continues from test_sequential with PC 0x8 at the buffer head.
    task automatic test_stall();
        bit ok;
        logic [31:0] exp_pc;
        StallF = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || InstrValidF !== 1'b1 || PCF !== 32'h8 ||
            InstrF !== 32'hA000_0008) begin
            n_fail++;
            $display("FAIL stall_hold: req=%b valid=%b pc=%h instr=%h, required req=0 valid=1 pc=00000008 instr=a0000008",
                     imem_req, InstrValidF, PCF, InstrF);
        end
        StallF = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_pc = 32'h0C + 32'(k * 4);
            wait_valid(ok);
            n_cmp++;
            if (!ok || PCF !== exp_pc || InstrF !== (32'hA000_0000 | exp_pc) ||
                branched_flag_F !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_release%0d: valid=%b pc=%h instr=%h flag=%b, required pc=%h flag=0",
                         k, ok, PCF, InstrF, branched_flag_F, exp_pc);
            end
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        do_reset();
        m_gnt = 1'b1;
        @(posedge clk); #1;
        m_gnt = 1'b0; PCSrcE = 2'b01; TargetE = 32'h100;
        @(posedge clk); #1;
        n_cmp++;
        if (InstrValidF !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_wait_drain: valid=%b req=%b, required valid=0 req=0", InstrValidF, imem_req);
        end
        PCSrcE = 2'b00; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        n_cmp++;
        if (InstrValidF !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_wait_discard: valid=%b req=%b addr=%h, required valid=0 req=1 addr=00000100",
                     InstrValidF, imem_req, imem_addr);
        end
        m_rvalid = 1'b0;
        auto_mem = 1'b1;
        wait_valid(ok);
        n_cmp++;
        if (!ok || PCF !== 32'h100 || InstrF !== 32'hA000_0100 || branched_flag_F !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_wait_target: valid=%b pc=%h instr=%h flag=%b, required pc=00000100 instr=a0000100 flag=1",
                     ok, PCF, InstrF, branched_flag_F);
        end
        wait_valid(ok);
        n_cmp++;
        if (!ok || PCF !== 32'h104 || InstrF !== 32'hA000_0104 || branched_flag_F !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_wait_next: valid=%b pc=%h instr=%h flag=%b, required pc=00000104 instr=a0000104 flag=0",
                     ok, PCF, InstrF, branched_flag_F);
        end
    endtask

    task automatic test_redirect_issue();
        bit ok;
        do_reset();
        m_gnt = 1'b0; PCSrcE = 2'b10; TargetE = 32'h203;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            PCSrcE = 2'b00;
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
                n_fail++;
                $display("FAIL redir_issue_hold%0d: req=%b addr=%h, required req=1 addr=00000000",
                         k, imem_req, imem_addr);
            end
        end
        m_gnt = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (imem_req !== 1'b0 || InstrValidF !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_issue_drain: req=%b valid=%b, required req=0 valid=0", imem_req, InstrValidF);
        end
        m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hBAD0_0000;
        @(posedge clk); #1;
        n_cmp++;
        if (InstrValidF !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_issue_newaddr: valid=%b req=%b addr=%h, required valid=0 req=1 addr=00000200",
                     InstrValidF, imem_req, imem_addr);
        end
        m_rvalid = 1'b0;
        auto_mem = 1'b1;
        wait_valid(ok);
        n_cmp++;
        if (!ok || PCF !== 32'h200 || InstrF !== 32'hA000_0200 || branched_flag_F !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_issue_target: valid=%b pc=%h instr=%h flag=%b, required pc=00000200 instr=a0000200 flag=1",
                     ok, PCF, InstrF, branched_flag_F);
        end
    endtask

    task automatic test_redirect_rvalid_full();
        bit ok;
        do_reset();
        StallF = 1'b1;
        m_gnt = 1'b1;
        @(posedge clk); #1;
        m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1111_0000;
        @(posedge clk); #1;
        n_cmp++;
        if (InstrValidF !== 1'b1 || PCF !== 32'h0 || InstrF !== 32'h1111_0000) begin
            n_fail++;
            $display("FAIL full_first_push: valid=%b pc=%h instr=%h, required valid=1 pc=00000000 instr=11110000",
                     InstrValidF, PCF, InstrF);
        end
        m_rvalid = 1'b0; m_gnt = 1'b1;
        @(posedge clk); #1;
        m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h2222_0004;
        PCSrcE = 2'b01; TargetE = 32'h300;
        @(posedge clk); #1;
        n_cmp++;
        if (InstrValidF !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL full_redir_flush: valid=%b req=%b addr=%h, required valid=0 req=1 addr=00000300",
                     InstrValidF, imem_req, imem_addr);
        end
        PCSrcE = 2'b00; m_rvalid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (InstrValidF !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_push: valid=%b pc=%h, required valid=0", InstrValidF, PCF);
        end
        StallF = 1'b0;
        auto_mem = 1'b1;
        wait_valid(ok);
        n_cmp++;
        if (!ok || PCF !== 32'h300 || InstrF !== 32'hA000_0300 || branched_flag_F !== 1'b1) begin
            n_fail++;
            $display("FAIL full_target: valid=%b pc=%h instr=%h flag=%b, required pc=00000300 instr=a0000300 flag=1",
                     ok, PCF, InstrF, branched_flag_F);
        end
    endtask

    task automatic test_reset_in_drain();
        bit ok;
        do_reset();
        m_gnt = 1'b1;
        @(posedge clk); #1;
        m_gnt = 1'b0; PCSrcE = 2'b01; TargetE = 32'h400;
        @(posedge clk); #1;
        PCSrcE = 2'b00;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_entry: req=%b, required 0", imem_req);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || InstrValidF !== 1'b0 ||
            InstrF !== 32'h0000_0013 || PCF !== 32'h0 || PCPlus4F !== 32'h4 ||
            branched_flag_F !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_async_reset: req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h flag=%b, required 1 0 0 00000013 0 4 0",
                     imem_req, imem_addr, InstrValidF, InstrF, PCF, PCPlus4F, branched_flag_F);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_0400;
        @(posedge clk); #1;
        n_cmp++;
        if (InstrValidF !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL drain_late_rvalid: valid=%b req=%b addr=%h, required valid=0 req=1 addr=00000000",
                     InstrValidF, imem_req, imem_addr);
        end
        m_rvalid = 1'b0;
        auto_mem = 1'b1;
        wait_valid(ok);
        n_cmp++;
        if (!ok || PCF !== 32'h0 || InstrF !== 32'hA000_0000 || branched_flag_F !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_restart: valid=%b pc=%h instr=%h flag=%b, required pc=00000000 instr=a0000000 flag=0",
                     ok, PCF, InstrF, branched_flag_F);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_issue();
        test_redirect_rvalid_full();
        test_reset_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
